// File: rtl/pixel_pkg.sv
// Purpose: shared types and constants for the 24-bit pixel to 32-bit byte-stream packer.
// Contents: PACK/FLUSH state encoding, byte-lane constants, pixel/word widths, frame geometry,
//           and a helper that turns a pending-byte count into a tkeep mask.
package pixel_pkg;

    localparam int PIXEL_W = 24;
    localparam int WORD_W  = 32;
    localparam int BYTE_W  = 8;
    localparam int LANES   = WORD_W / BYTE_W;
    localparam int X_SIZE  = 640;
    localparam int Y_SIZE  = 480;

    localparam logic [LANES-1:0] KEEP_FULL = 4'hF;

    typedef enum logic {
        PACK  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // n pending bytes occupy lanes 0..n-1, so the mask is n low-order ones.
    function automatic logic [LANES-1:0] keep_mask(input logic [1:0] n);
        return (4'b0001 << n) - 4'b0001;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Purpose: output word register for the packed stream; holds its contents under backpressure.
// Latency: one cycle from load to tvalid. Backpressure: contents frozen while tvalid && !tready.
// Ports: load + ld_* (next word), tready in; tdata/tkeep/tlast/tuser/tvalid out; can_load = slot free.
module axis_out_reg
    import pixel_pkg::*;
(
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                load,
    input  logic [WORD_W-1:0]   ld_data,
    input  logic [LANES-1:0]    ld_keep,
    input  logic                ld_last,
    input  logic                ld_user,
    input  logic                tready,
    output logic [WORD_W-1:0]   tdata,
    output logic [LANES-1:0]    tkeep,
    output logic                tlast,
    output logic                tuser,
    output logic                tvalid,
    output logic                can_load
);

    // The register may take a new word when it is empty or its word leaves on this edge.
    assign can_load = !tvalid || tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tdata  <= '0;
            tkeep  <= '0;
            tlast  <= 1'b0;
            tuser  <= 1'b0;
            tvalid <= 1'b0;
        end else if (load) begin
            tdata  <= ld_data;
            tkeep  <= ld_keep;
            tlast  <= ld_last;
            tuser  <= ld_user;
            tvalid <= 1'b1;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_packer.sv
// Purpose: serialise 24-bit {r,g,b} pixels as bytes b,g,r into a 32-bit stream with tkeep/tlast/tuser.
// Latency: one cycle from accepting edge to word valid. Backpressure: in_stream_ready drops while
//          the output word is stalled, during a flush, and while a sof pixel waits for pending bytes.
module pixel_packer
    import pixel_pkg::*;
(
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [7:0]          r,
    input  logic [7:0]          g,
    input  logic [7:0]          b,
    input  logic                valid,
    input  logic                sof,
    input  logic                eol,
    output logic                in_stream_ready,
    output logic [WORD_W-1:0]   out_stream_tdata,
    output logic [LANES-1:0]    out_stream_tkeep,
    output logic                out_stream_tlast,
    output logic                out_stream_tuser,
    output logic                out_stream_tvalid,
    input  logic                out_stream_tready
);

    state_t               state;
    logic [PIXEL_W-1:0]   acc;        // pending bytes, lane 0 at [7:0]; unused bytes kept zero
    logic [1:0]           acc_cnt;
    logic                 acc_sof;    // lane 0 of the pending bytes is the b byte of a sof pixel
    logic                 run;        // low from reset until the first clock edge after release

    logic                 can_load;
    logic                 sof_block;
    logic                 accept;
    logic [2*PIXEL_W-1:0] comb_bytes;
    logic [2:0]           total;
    logic                 emit;
    logic [1:0]           new_cnt;
    logic                 flush_load;
    logic                 ld;
    logic [WORD_W-1:0]    ld_data;
    logic [LANES-1:0]     ld_keep;
    logic                 ld_last;
    logic                 ld_user;

    always_comb begin
        // A sof pixel must start at lane 0, so it is refused until the pending bytes are flushed.
        sof_block       = valid && sof && (acc_cnt != 2'd0);
        in_stream_ready = run && (state == PACK) && can_load && !sof_block;
        accept          = valid && in_stream_ready;

        comb_bytes = {24'b0, acc} | ({24'b0, r, g, b} << {acc_cnt, 3'b000});
        total      = {1'b0, acc_cnt} + 3'd3;
        emit       = total[2];
        new_cnt    = total[1:0];
        flush_load = (state == FLUSH) && can_load;
        ld         = (accept && emit) || flush_load;

        ld_data = comb_bytes[WORD_W-1:0];
        ld_keep = KEEP_FULL;
        ld_last = eol && (new_cnt == 2'd0);
        ld_user = acc_sof;
        if (flush_load) begin
            ld_data = {8'b0, acc};
            ld_keep = keep_mask(acc_cnt);
            ld_last = 1'b1;
            ld_user = acc_sof;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= PACK;
            acc     <= '0;
            acc_cnt <= 2'd0;
            acc_sof <= 1'b0;
            run     <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                PACK: begin
                    if (accept) begin
                        acc     <= emit ? {8'b0, comb_bytes[2*PIXEL_W-1:WORD_W]} : comb_bytes[PIXEL_W-1:0];
                        acc_cnt <= new_cnt;
                        // Any word emitted here carries the old lane 0, so the flag only survives
                        // when the pixel lands in an empty accumulator.
                        acc_sof <= (acc_cnt == 2'd0) ? sof : 1'b0;
                        if (eol && (new_cnt != 2'd0)) begin
                            state <= FLUSH;
                        end
                    end else if (sof_block) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (can_load) begin
                        acc     <= '0;
                        acc_cnt <= 2'd0;
                        acc_sof <= 1'b0;
                        state   <= PACK;
                    end
                end
                default: state <= PACK;
            endcase
        end
    end

    axis_out_reg u_out (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (ld),
        .ld_data  (ld_data),
        .ld_keep  (ld_keep),
        .ld_last  (ld_last),
        .ld_user  (ld_user),
        .tready   (out_stream_tready),
        .tdata    (out_stream_tdata),
        .tkeep    (out_stream_tkeep),
        .tlast    (out_stream_tlast),
        .tuser    (out_stream_tuser),
        .tvalid   (out_stream_tvalid),
        .can_load (can_load)
    );

endmodule

// File: tb/tb_pixel_packer.sv
// Purpose: directed checks of pixel_packer: table of single-cycle vectors plus line, stall and reset sequences.
// Latency: n/a. Backpressure: stimulated explicitly through out_stream_tready.
module tb_pixel_packer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  r, g, b;
    logic        valid, sof, eol;
    logic        in_stream_ready;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast, tuser, tvalid;
    logic        tready;

    int n_cmp = 0;
    int n_bad = 0;

    pixel_packer dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .r                 (r),
        .g                 (g),
        .b                 (b),
        .valid             (valid),
        .sof               (sof),
        .eol               (eol),
        .in_stream_ready   (in_stream_ready),
        .out_stream_tdata  (tdata),
        .out_stream_tkeep  (tkeep),
        .out_stream_tlast  (tlast),
        .out_stream_tuser  (tuser),
        .out_stream_tvalid (tvalid),
        .out_stream_tready (tready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic [23:0] pix;
        logic        s;
        logic        e;
        logic        rdy;
        logic        o_vld;
        logic [31:0] o_dat;
        logic [3:0]  o_keep;
        logic        o_last;
        logic        o_user;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [23:0] pix, input logic s, input logic e,
                                input logic rdy, input logic o_vld, input logic [31:0] o_dat,
                                input logic [3:0] o_keep, input logic o_last, input logic o_user);
        vec_t t;
        t.v = v; t.pix = pix; t.s = s; t.e = e; t.rdy = rdy;
        t.o_vld = o_vld; t.o_dat = o_dat; t.o_keep = o_keep; t.o_last = o_last; t.o_user = o_user;
        return t;
    endfunction

    // Streams n pixels (sof first, eol last) with tready low for slen cycles from cycle s0,
    // checking every transferred word against a byte-queue model and hold behaviour under stall.
    task automatic stream(input string tag, input int n, input int s0, input int slen, input logic [7:0] seed);
        logic [7:0]  q[$];
        int          k = 0;
        int          w = 0;
        int          cyc = 0;
        int          nw = n * 3 / 4;
        logic        held = 1'b0;
        logic [31:0] snap_d;
        logic [6:0]  snap_c;
        logic [31:0] exp;
        while ((k < n || w < nw) && cyc < 4 * n + 50) begin
            tready = !(cyc >= s0 && cyc < s0 + slen);
            valid  = (k < n);
            r      = k[7:0] ^ seed;
            g      = k[15:8] + seed;
            b      = ~k[7:0];
            sof    = (k == 0);
            eol    = (k == n - 1);
            #1;
            if (held) begin
                chk({tag, "_hold_dat"}, tdata, snap_d);
                chk({tag, "_hold_ctl"}, {25'b0, tkeep, tlast, tuser, tvalid}, {25'b0, snap_c});
            end
            if (tvalid && !tready) chk({tag, "_stall_rdy"}, in_stream_ready, 0);
            if (tvalid && tready) begin
                if (q.size() >= 4) exp = {q[3], q[2], q[1], q[0]};
                else               exp = 32'hxxxx_xxxx;
                chk({tag, "_word_dat"}, tdata, exp);
                chk({tag, "_word_ctl"}, {26'b0, tkeep, tlast, tuser},
                    {26'b0, 4'hF, (w == nw - 1), (w == 0)});
                for (int i = 0; i < 4 && q.size() > 0; i++) void'(q.pop_front());
                w++;
            end
            if (valid && in_stream_ready) begin
                q.push_back(b);
                q.push_back(g);
                q.push_back(r);
                k++;
            end
            held   = tvalid && !tready;
            snap_d = tdata;
            snap_c = {tkeep, tlast, tuser, tvalid};
            @(posedge aclk); #1;
            cyc++;
        end
        valid = 1'b0; sof = 1'b0; eol = 1'b0; tready = 1'b1;
        chk({tag, "_pixels"}, k, n);
        chk({tag, "_words"}, w, nw);
        chk({tag, "_no_extra"}, tvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0;
        r = 8'h0; g = 8'h0; b = 8'h0;
        valid = 1'b0; sof = 1'b0; eol = 1'b0; tready = 1'b1;

        //        v  pix        s  e  rdy vld dat           keep    last user
        tbl.push_back(mk(1, 24'h010203, 0, 0, 1, 0, 32'h0,        4'h0,    0, 0));
        tbl.push_back(mk(1, 24'h040506, 0, 0, 1, 1, 32'h06010203, 4'hF,    0, 0));
        tbl.push_back(mk(1, 24'h070809, 0, 0, 1, 1, 32'h08090405, 4'hF,    0, 0));
        tbl.push_back(mk(1, 24'h0A0B0C, 0, 0, 1, 1, 32'h0A0B0C07, 4'hF,    0, 0));
        tbl.push_back(mk(0, 24'h000000, 0, 0, 1, 0, 32'h0,        4'h0,    0, 0));
        // sof pixel then eol pixel: full word then a two-byte flush
        tbl.push_back(mk(1, 24'h112233, 1, 0, 1, 0, 32'h0,        4'h0,    0, 0));
        tbl.push_back(mk(1, 24'h445566, 0, 1, 1, 1, 32'h66112233, 4'hF,    0, 1));
        tbl.push_back(mk(0, 24'h000000, 0, 0, 0, 1, 32'h00004455, 4'b0011, 1, 0));
        // one pixel then sof: three-byte flush, sof pixel restarts at lane 0
        tbl.push_back(mk(1, 24'h778899, 0, 0, 1, 0, 32'h0,        4'h0,    0, 0));
        tbl.push_back(mk(1, 24'hAABBCC, 1, 0, 0, 0, 32'h0,        4'h0,    0, 0));
        tbl.push_back(mk(1, 24'hAABBCC, 1, 0, 0, 1, 32'h00778899, 4'b0111, 1, 0));
        tbl.push_back(mk(1, 24'hAABBCC, 1, 0, 1, 0, 32'h0,        4'h0,    0, 0));
        tbl.push_back(mk(1, 24'hDDEEFF, 0, 1, 1, 1, 32'hFFAABBCC, 4'hF,    0, 1));
        tbl.push_back(mk(0, 24'h000000, 0, 0, 0, 1, 32'h0000DDEE, 4'b0011, 1, 0));
        // single eol pixel into an empty accumulator
        tbl.push_back(mk(1, 24'h123456, 0, 1, 1, 0, 32'h0,        4'h0,    0, 0));
        tbl.push_back(mk(0, 24'h000000, 0, 0, 0, 1, 32'h00123456, 4'b0111, 1, 0));
        // eol landing with two bytes pending: full word tlast=0, one-byte flush
        tbl.push_back(mk(1, 24'h0A0B0C, 0, 0, 1, 0, 32'h0,        4'h0,    0, 0));
        tbl.push_back(mk(1, 24'h0D0E0F, 0, 0, 1, 1, 32'h0F0A0B0C, 4'hF,    0, 0));
        tbl.push_back(mk(1, 24'h102030, 0, 1, 1, 1, 32'h20300D0E, 4'hF,    0, 0));
        tbl.push_back(mk(0, 24'h000000, 0, 0, 0, 1, 32'h00000010, 4'b0001, 1, 0));
        tbl.push_back(mk(0, 24'h000000, 0, 0, 1, 0, 32'h0,        4'h0,    0, 0));

        // reset state
        #12;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_ctl", {tkeep, tlast, tuser}, 0);
        chk("rst_ready", in_stream_ready, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("ready_after_rst", in_stream_ready, 1);

        foreach (tbl[i]) begin
            valid = tbl[i].v;
            {r, g, b} = tbl[i].pix;
            sof = tbl[i].s;
            eol = tbl[i].e;
            tready = 1'b1;
            #1;
            chk($sformatf("vec%0d_ready", i), in_stream_ready, tbl[i].rdy);
            @(posedge aclk); #1;
            chk($sformatf("vec%0d_tvalid", i), tvalid, tbl[i].o_vld);
            if (tbl[i].o_vld) begin
                chk($sformatf("vec%0d_tdata", i), tdata, tbl[i].o_dat);
                chk($sformatf("vec%0d_ctl", i), {26'b0, tkeep, tlast, tuser},
                    {26'b0, tbl[i].o_keep, tbl[i].o_last, tbl[i].o_user});
            end
        end
        valid = 1'b0; sof = 1'b0; eol = 1'b0;

        // full 640-pixel line, then a short line with a 5-cycle stall
        stream("line", 640, 0, 0, 8'h3C);
        stream("stall", 8, 3, 5, 8'hA5);

        // reset mid-word with a stalled word in the output register
        tready = 1'b0;
        valid = 1'b1; {r, g, b} = 24'h010203;
        @(posedge aclk); #1;
        {r, g, b} = 24'h040506;
        @(posedge aclk); #1;
        valid = 1'b0;
        chk("pre_rst_tvalid", tvalid, 1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", tvalid, 0);
        chk("mid_rst_tdata", tdata, 0);
        chk("mid_rst_ctl", {tkeep, tlast, tuser}, 0);
        chk("mid_rst_ready", in_stream_ready, 0);
        @(posedge aclk); #1;
        chk("held_rst_ready", in_stream_ready, 0);
        aresetn = 1'b1;
        tready = 1'b1;
        @(posedge aclk); #1;
        chk("rerun_ready", in_stream_ready, 1);
        valid = 1'b1; {r, g, b} = 24'h0A0B0C;
        @(posedge aclk); #1;
        chk("post_rst_first_tvalid", tvalid, 0);
        {r, g, b} = 24'h0D0E0F;
        @(posedge aclk); #1;
        valid = 1'b0;
        chk("post_rst_tvalid", tvalid, 1);
        chk("post_rst_tdata", tdata, 32'h0F0A0B0C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
